// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves forwarded ALU operands on the decode side and
// captures them into a two-entry skid buffer with registered ready/valid handshakes.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_alu_op,
    input  logic [DATA_W-1:0] in_rs1_val,
    input  logic [DATA_W-1:0] in_rs2_val,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [4:0]        in_rs1_addr,
    input  logic [4:0]        in_rs2_addr,
    input  logic [4:0]        in_rd_addr,
    input  logic              fwd_mem_en,
    input  logic [4:0]        fwd_mem_rd,
    input  logic [DATA_W-1:0] fwd_mem_data,
    input  logic              fwd_wb_en,
    input  logic [4:0]        fwd_wb_rd,
    input  logic [DATA_W-1:0] fwd_wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_alu_op,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [4:0]        out_rd_addr
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_MAIN,
        ST_FULL
    } state_t;

    state_t state_q, state_d;

    logic [OP_W-1:0]   main_op,   skid_op;
    logic [DATA_W-1:0] main_a,    skid_a;
    logic [DATA_W-1:0] main_b,    skid_b;
    logic [4:0]        main_rd,   skid_rd;

    logic              accept, drain;
    logic              load_main_in, load_main_skid, load_skid;

    logic              mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
    logic [DATA_W-1:0] res_a, res_rs2, res_b;

    // x0 is hard-wired to zero, so a writeback targeting it must never be forwarded.
    assign mem_hit_a = fwd_mem_en && (in_rs1_addr != 5'd0) && (fwd_mem_rd == in_rs1_addr);
    assign wb_hit_a  = fwd_wb_en  && (in_rs1_addr != 5'd0) && (fwd_wb_rd  == in_rs1_addr);
    assign mem_hit_b = fwd_mem_en && (in_rs2_addr != 5'd0) && (fwd_mem_rd == in_rs2_addr);
    assign wb_hit_b  = fwd_wb_en  && (in_rs2_addr != 5'd0) && (fwd_wb_rd  == in_rs2_addr);

    assign res_a   = mem_hit_a ? fwd_mem_data : (wb_hit_a ? fwd_wb_data : in_rs1_val);
    assign res_rs2 = mem_hit_b ? fwd_mem_data : (wb_hit_b ? fwd_wb_data : in_rs2_val);
    assign res_b   = in_use_imm ? in_imm : res_rs2;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_d      = ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = ST_FULL;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the skid-to-main move can happen.
                    if (drain) begin
                        load_main_skid = 1'b1;
                        state_d        = ST_MAIN;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Handshake flags are registered from the next state so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d != ST_EMPTY);
            in_ready  <= (state_d != ST_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_op <= '0;
            main_a  <= '0;
            main_b  <= '0;
            main_rd <= '0;
        end else if (load_main_in) begin
            main_op <= in_alu_op;
            main_a  <= res_a;
            main_b  <= res_b;
            main_rd <= in_rd_addr;
        end else if (load_main_skid) begin
            main_op <= skid_op;
            main_a  <= skid_a;
            main_b  <= skid_b;
            main_rd <= skid_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_op <= '0;
            skid_a  <= '0;
            skid_b  <= '0;
            skid_rd <= '0;
        end else if (load_skid) begin
            skid_op <= in_alu_op;
            skid_a  <= res_a;
            skid_b  <= res_b;
            skid_rd <= in_rd_addr;
        end
    end

    assign out_alu_op  = main_op;
    assign out_a       = main_a;
    assign out_b       = main_b;
    assign out_rd_addr = main_rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a random mix,
// with a scoreboard queue filled on accept and drained on output transfer.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [4:0]        rd;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready;
    logic [OP_W-1:0]   in_alu_op;
    logic [DATA_W-1:0] in_rs1_val, in_rs2_val, in_imm;
    logic              in_use_imm;
    logic [4:0]        in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic              fwd_mem_en, fwd_wb_en;
    logic [4:0]        fwd_mem_rd, fwd_wb_rd;
    logic [DATA_W-1:0] fwd_mem_data, fwd_wb_data;
    logic              flush;
    logic              out_valid, out_ready;
    logic [OP_W-1:0]   out_alu_op;
    logic [DATA_W-1:0] out_a, out_b;
    logic [4:0]        out_rd_addr;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    logic sampOv, sampIr;

    id_ex_stage #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_a(out_a), .out_b(out_b), .out_rd_addr(out_rd_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] fwdModel(input logic [4:0] addr, input logic [DATA_W-1:0] regval);
        if (addr == 5'd0) return regval;
        if (fwd_mem_en && fwd_mem_rd == addr) return fwd_mem_data;
        if (fwd_wb_en && fwd_wb_rd == addr) return fwd_wb_data;
        return regval;
    endfunction

    function automatic exp_t model();
        exp_t e;
        e.op = in_alu_op;
        e.a  = fwdModel(in_rs1_addr, in_rs1_val);
        e.b  = in_use_imm ? in_imm : fwdModel(in_rs2_addr, in_rs2_val);
        e.rd = in_rd_addr;
        return e;
    endfunction

    task automatic applyStimulus(input logic v, input logic [OP_W-1:0] op,
                                 input logic [4:0] r1a, input logic [DATA_W-1:0] r1v,
                                 input logic [4:0] r2a, input logic [DATA_W-1:0] r2v,
                                 input logic [DATA_W-1:0] imm, input logic ui, input logic [4:0] rd);
        in_valid = v;   in_alu_op = op;
        in_rs1_addr = r1a; in_rs1_val = r1v;
        in_rs2_addr = r2a; in_rs2_val = r2v;
        in_imm = imm;   in_use_imm = ui; in_rd_addr = rd;
    endtask

    task automatic setFwd(input logic men, input logic [4:0] mrd, input logic [DATA_W-1:0] mdata,
                          input logic wen, input logic [4:0] wrd, input logic [DATA_W-1:0] wdata);
        fwd_mem_en = men; fwd_mem_rd = mrd; fwd_mem_data = mdata;
        fwd_wb_en  = wen; fwd_wb_rd  = wrd; fwd_wb_data  = wdata;
    endtask

    task automatic applyRandom(input logic v);
        applyStimulus(v, OP_W'($urandom), 5'($urandom_range(0, 3)), $urandom,
                      5'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom), 5'($urandom));
    endtask

    // Sample at the falling edge, score the transfers, then advance to just after the rising edge.
    task automatic stepCycle();
        exp_t e;
        logic acc, drn;
        @(negedge clk);
        sampOv = out_valid;
        sampIr = in_ready;
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (drn) begin
            if (sbq.size() == 0) begin
                checkOutput("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                e = sbq.pop_front();
                checkOutput("out_op", 64'(out_alu_op), 64'(e.op));
                checkOutput("out_a", 64'(out_a), 64'(e.a));
                checkOutput("out_b", 64'(out_b), 64'(e.b));
                checkOutput("out_rd", 64'(out_rd_addr), 64'(e.rd));
            end
        end
        if (flush) sbq.delete();
        else if (acc) sbq.push_back(model());
        @(posedge clk);
        #1;
    endtask

    task automatic drainAll(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (sbq.size() != 0 || out_valid); i++) stepCycle();
        checkOutput(tag, 64'(sbq.size()), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        setFwd(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
        checkOutput("rst_out_a", 64'(out_a), 64'(0));
        checkOutput("rst_out_b", 64'(out_b), 64'(0));
        checkOutput("rst_out_op_rd", 64'({out_alu_op, out_rd_addr}), 64'(0));
        rst_n = 1'b1;

        // Forwarding priority: EX/MEM wins over MEM/WB
        out_ready = 1'b1;
        setFwd(1, 5, 32'h11, 1, 5, 32'h22);
        applyStimulus(1, 4'h3, 5, 32'h33, 6, 32'h44, 32'h99, 0, 7);
        stepCycle();
        checkOutput("fwd_prio_a", 64'(out_a), 64'h11);
        checkOutput("fwd_prio_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b0;
        stepCycle();

        // MEM/WB only, feeding both A and B
        setFwd(0, 5, 32'h11, 1, 5, 32'h22);
        applyStimulus(1, 4'h5, 5, 32'h33, 5, 32'h44, 32'h99, 0, 9);
        stepCycle();
        checkOutput("fwd_wb_a", 64'(out_a), 64'h22);
        checkOutput("fwd_wb_b", 64'(out_b), 64'h22);
        in_valid = 1'b0;
        stepCycle();

        // x0 is never forwarded
        setFwd(1, 0, 32'hFF, 0, 0, 0);
        applyStimulus(1, 4'h1, 0, 32'h0, 0, 32'h0, 32'h7, 0, 1);
        stepCycle();
        checkOutput("x0_guard_a", 64'(out_a), 64'h0);
        checkOutput("x0_guard_b", 64'(out_b), 64'h0);
        in_valid = 1'b0;
        stepCycle();

        // Immediate overrides a forwarding match on rs2
        setFwd(1, 4, 32'hAAAA, 1, 4, 32'hBBBB);
        applyStimulus(1, 4'hC, 4, 32'h1, 4, 32'h2, 32'hFFFF_FFF0, 1, 31);
        stepCycle();
        checkOutput("imm_b", 64'(out_b), 64'hFFFF_FFF0);
        checkOutput("imm_rd", 64'(out_rd_addr), 64'd31);
        in_valid = 1'b0;
        stepCycle();
        setFwd(0, 0, 0, 0, 0, 0);

        // Streaming: eight back-to-back transfers with no bubbles
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyRandom(1);
            stepCycle();
            if (i > 0) checkOutput("stream_ov", 64'(sampOv), 64'(1));
        end
        in_valid = 1'b0;
        stepCycle();
        checkOutput("stream_last_ov", 64'(sampOv), 64'(1));
        checkOutput("stream_count", 64'(sbq.size()), 64'(0));

        // Backpressure: two accepted, third stalls until the skid drains
        out_ready = 1'b0;
        applyRandom(1); stepCycle();
        applyRandom(1); stepCycle();
        applyRandom(1); stepCycle();
        checkOutput("bp_ir_third", 64'(sampIr), 64'(0));
        checkOutput("bp_queued", 64'(sbq.size()), 64'(2));
        out_ready = 1'b1;
        stepCycle();
        checkOutput("bp_ir_drain", 64'(sampIr), 64'(0));
        stepCycle();
        checkOutput("bp_ir_rise", 64'(sampIr), 64'(1));
        drainAll("bp_drained");

        // Flush with both entries full and an instruction waiting
        out_ready = 1'b0;
        applyRandom(1); stepCycle();
        applyRandom(1); stepCycle();
        applyRandom(1);
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_full_ov", 64'(out_valid), 64'(0));
        checkOutput("flush_full_ir", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        repeat (3) stepCycle();

        // Flush drops a same-cycle accept
        out_ready = 1'b0;
        applyRandom(1); stepCycle();
        applyRandom(1);
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_acc_ov", 64'(out_valid), 64'(0));
        checkOutput("flush_acc_ir", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        repeat (3) stepCycle();

        // Asynchronous reset between edges with both entries full
        out_ready = 1'b0;
        applyRandom(1); stepCycle();
        applyStimulus(1, 4'hF, 1, 32'hDEAD_BEEF, 2, 32'hCAFE_F00D, 32'h1234, 0, 17);
        stepCycle();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_ov", 64'(out_valid), 64'(0));
        checkOutput("arst_ir", 64'(in_ready), 64'(1));
        checkOutput("arst_a", 64'(out_a), 64'(0));
        checkOutput("arst_b", 64'(out_b), 64'(0));
        checkOutput("arst_op_rd", 64'({out_alu_op, out_rd_addr}), 64'(0));
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) stepCycle();

        // Random mix of valid, backpressure and forwarding
        for (int i = 0; i < 80; i++) begin
            setFwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                   1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            applyRandom(1'($urandom));
            out_ready = 1'($urandom);
            stepCycle();
        end
        drainAll("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/datapath width.
REQ-002 SHALL have parameter OP_W, default 4, ALU opcode width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-005 in_valid  in  1  decode stage presents an instruction.
REQ-006 in_ready  out  1  stage accepts; transfer when in_valid & in_ready.
REQ-007 in_alu_op  in  OP_W  ALU opcode.
REQ-008 in_rs1_val, in_rs2_val  in  DATA_W each  register-file read data.
REQ-009 in_imm  in  DATA_W  sign-extended immediate.
REQ-010 in_use_imm  in  1  1: B operand = in_imm; 0: B = forwarded rs2.
REQ-011 in_rs1_addr, in_rs2_addr, in_rd_addr  in  5 each  register indices.
REQ-012 fwd_mem_en, fwd_mem_rd, fwd_mem_data  in  1/5/DATA_W  EX/MEM writeback candidate.
REQ-013 fwd_wb_en, fwd_wb_rd, fwd_wb_data  in  1/5/DATA_W  MEM/WB writeback candidate.
REQ-014 flush  in  1  discard all held and incoming instructions.
REQ-015 out_valid  out  1  ALU operands valid.
REQ-016 out_ready  in  1  execute stage consumes; transfer when out_valid & out_ready.
REQ-017 out_alu_op, out_a, out_b, out_rd_addr  out  OP_W/DATA_W/DATA_W/5  registered ALU inputs and destination.

Function
REQ-018 Operand resolution SHALL occur combinationally on the input side before capture; operand A per source: fwd_mem match, else fwd_wb match, else in_rs1_val.
REQ-019 Match SHALL require en=1, rd==addr, addr!=0; EX/MEM has priority over MEM/WB when both match.
REQ-020 rs2 resolution SHALL use identical rules; out_b = in_imm when in_use_imm=1 regardless of forwarding.
REQ-021 Storage SHALL be a 2-entry skid buffer: main entry drives outputs, skid entry holds one overflow instruction.
REQ-022 in_ready SHALL be registered, equal to NOT skid_valid; no combinational path from out_ready to in_ready.
REQ-023 Latency SHALL be 1 cycle: instruction accepted at edge N appears on outputs after edge N when main entry empty or draining.
REQ-024 Accept while main full and not draining SHALL write skid entry; in_ready falls next cycle.
REQ-025 When main drains and skid valid, skid SHALL move to main same edge; in_ready rises next cycle.
REQ-026 Simultaneous accept and drain with skid empty SHALL replace main entry, out_valid stays 1, no bubble.
REQ-027 Output fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 Order SHALL be preserved; no instruction duplicated or dropped except by flush.
REQ-029 flush=1 SHALL clear main and skid valid at the edge, drop any same-cycle input transfer, force in_ready=1 next cycle; data fields need not clear.
REQ-030 flush SHALL take priority over all simultaneous accept/drain events.
REQ-031 Arithmetic: none; all widths pass through unchanged, no truncation.

Reset
REQ-032 rst_n=0 SHALL asynchronously force out_valid=0, skid_valid=0, in_ready=1, out_alu_op=0, out_a=0, out_b=0, out_rd_addr=0.
REQ-033 Reset deasserted mid-transfer SHALL yield empty stage; first accept occurs on first edge with rst_n=1.

Verification
REQ-034 Forward priority: rs1=5, fwd_mem(en,5,0x11), fwd_wb(en,5,0x22), rs1_val=0x33 -> out_a=0x11 one cycle later.
REQ-035 x0 guard: rs1=0, fwd_mem(en,0,0xFF), rs1_val=0 -> out_a=0.
REQ-036 Backpressure: out_ready=0, three in_valid cycles -> two accepted, in_ready=0 on third; out_ready=1 -> outputs in order, in_ready=1 after skid drains.
REQ-037 Streaming: in_valid=out_ready=1 for 8 cycles -> 8 outputs, out_valid continuously 1 after first, no bubbles.
REQ-038 Flush: both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming instruction never appears.
REQ-039 Async reset: assert rst_n=0 between edges with entries full -> out_valid=0 and outputs zero immediately, before next clk edge.
